// File: rtl/fbuf_port_sched.sv
// fbuf_port_sched: framebuffer port arbiter between the blitter and the
// screen-wide CLEAR / SCROLL sequencer (64 rows x 8 words x 16 bits).
module fbuf_port_sched (
    input  logic        clk,
    input  logic        res,
    input  logic        op_start,
    input  logic [1:0]  op_code,
    input  logic [3:0]  op_arg,
    output logic        op_busy,
    output logic        op_done,
    input  logic        blit_req,
    output logic        blit_gnt,
    input  logic        blit_en,
    input  logic        blit_write,
    input  logic [8:0]  blit_addr,
    input  logic [15:0] blit_data,
    output logic        fbuf_en,
    output logic        fbuf_write,
    output logic [8:0]  fbuf_addr,
    output logic [15:0] fbuf_data_in,
    input  logic [15:0] fbuf_data_out
);

    typedef enum logic [2:0] {IDLE, WAIT_GNT, RD, WR, ZWR, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_BLIT, OWN_ENG} owner_t;

    localparam logic [1:0] OP_CLEAR = 2'd0;
    localparam logic [1:0] OP_DOWN  = 2'd1;
    localparam logic [1:0] OP_LEFT  = 2'd3;

    state_t      state, state_nxt;
    owner_t      owner, last_owner;
    logic [1:0]  op_q;
    logic [3:0]  n_q;
    logic [5:0]  row;
    logic [2:0]  w;
    logic [3:0]  carry;
    logic [5:0]  n_ext, src_row;
    logic        row_end, eng_req;
    logic        eng_en, eng_write;
    logic [8:0]  eng_addr;
    logic [15:0] eng_data, wr_data;

    assign n_ext   = {2'b00, n_q};
    assign src_row = (op_q == OP_DOWN) ? row - n_ext : row;
    assign row_end = (op_q == OP_LEFT) ? (w == 3'd0) : (w == 3'd7);
    // an accepted strobe already competes for the port in its own cycle
    assign eng_req = (state == WAIT_GNT) || (state == IDLE && op_start);

    // port ownership: grant only from NONE, alternate on ties
    always_ff @(posedge clk) begin
        if (res) begin
            owner      <= OWN_NONE;
            last_owner <= OWN_ENG;
        end else begin
            unique case (owner)
                OWN_NONE: begin
                    if (blit_req && (!eng_req || last_owner == OWN_ENG)) begin
                        owner      <= OWN_BLIT;
                        last_owner <= OWN_BLIT;
                    end else if (eng_req) begin
                        owner      <= OWN_ENG;
                        last_owner <= OWN_ENG;
                    end
                end
                OWN_BLIT: if (!blit_req) owner <= OWN_NONE;
                OWN_ENG:  if (state == DONE) owner <= OWN_NONE;
                default:  owner <= OWN_NONE;
            endcase
        end
    end

    // engine state register
    always_ff @(posedge clk) begin
        if (res) state <= IDLE;
        else     state <= state_nxt;
    end

    // engine next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (op_start) state_nxt = WAIT_GNT;
            WAIT_GNT: begin
                if (owner == OWN_ENG) begin
                    if (op_q == OP_CLEAR)
                        state_nxt = ZWR;
                    else if (op_q == OP_DOWN && n_q == 4'd0)
                        state_nxt = DONE;
                    else
                        state_nxt = RD;
                end
            end
            RD: state_nxt = WR;
            WR: begin
                if (!row_end)
                    state_nxt = RD;
                else if (op_q == OP_DOWN)
                    state_nxt = (row == n_ext) ? ZWR : RD;
                else
                    state_nxt = (row == 6'd63) ? DONE : RD;
            end
            ZWR: begin
                if (w == 3'd7 &&
                    row == ((op_q == OP_CLEAR) ? 6'd63 : 6'd0))
                    state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // operation registers and row/word walk
    always_ff @(posedge clk) begin
        if (res) begin
            op_q  <= 2'd0;
            n_q   <= 4'd0;
            row   <= 6'd0;
            w     <= 3'd0;
            carry <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (op_start) begin
                        op_q  <= op_code;
                        n_q   <= op_arg;
                        carry <= 4'd0;
                        row   <= (op_code == OP_DOWN) ? 6'd63 : 6'd0;
                        w     <= (op_code == OP_LEFT) ? 3'd7 : 3'd0;
                    end
                end
                WR: begin
                    if (row_end) begin
                        carry <= 4'd0;
                        row   <= (op_q == OP_DOWN) ? row - 6'd1 : row + 6'd1;
                        w     <= (op_q == OP_LEFT) ? 3'd7 : 3'd0;
                    end else begin
                        carry <= (op_q == OP_LEFT) ? fbuf_data_out[15:12]
                                                   : fbuf_data_out[3:0];
                        w     <= (op_q == OP_LEFT) ? w - 3'd1 : w + 3'd1;
                    end
                end
                ZWR: begin
                    w <= w + 3'd1;
                    if (w == 3'd7)
                        row <= (op_q == OP_CLEAR) ? row + 6'd1 : row - 6'd1;
                end
                default: ;
            endcase
        end
    end

    // write data: read word from the previous RD cycle, shifted with carry
    always_comb begin
        wr_data = fbuf_data_out;
        unique case (op_q)
            2'd2:    wr_data = {carry, fbuf_data_out[15:4]};
            OP_LEFT: wr_data = {fbuf_data_out[11:0], carry};
            default: wr_data = fbuf_data_out;
        endcase
    end

    // status outputs and port mux
    always_comb begin
        op_busy   = (state != IDLE);
        op_done   = (state == DONE);
        blit_gnt  = (owner == OWN_BLIT);
        eng_en    = (state == RD) || (state == WR) || (state == ZWR);
        eng_write = (state == WR) || (state == ZWR);
        eng_addr  = (state == RD) ? {src_row, w} : {row, w};
        eng_data  = (state == WR) ? wr_data : 16'h0000;
        fbuf_en      = 1'b0;
        fbuf_write   = 1'b0;
        fbuf_addr    = 9'd0;
        fbuf_data_in = 16'h0000;
        if (owner == OWN_BLIT) begin
            fbuf_en      = blit_en;
            fbuf_write   = blit_write;
            fbuf_addr    = blit_addr;
            fbuf_data_in = blit_data;
        end else if (owner == OWN_ENG) begin
            fbuf_en      = eng_en;
            fbuf_write   = eng_write;
            fbuf_addr    = eng_addr;
            fbuf_data_in = eng_data;
        end
    end

endmodule

// File: tb/tb_fbuf_port_sched.sv
// tb_fbuf_port_sched: directed vectors for fbuf_port_sched with a
// synchronous-read framebuffer model and a blitter driver.
module tb_fbuf_port_sched;

    logic        clk;
    logic        res;
    logic        op_start;
    logic [1:0]  op_code;
    logic [3:0]  op_arg;
    logic        op_busy, op_done;
    logic        blit_req, blit_gnt;
    logic        blit_en, blit_write;
    logic [8:0]  blit_addr;
    logic [15:0] blit_data;
    logic        fbuf_en, fbuf_write;
    logic [8:0]  fbuf_addr;
    logic [15:0] fbuf_data_in, fbuf_data_out;

    logic [15:0] mem [512];
    logic [15:0] rd_q;

    int ncmp = 0;
    int nfail = 0;

    typedef struct {
        logic [1:0] code;
        logic [3:0] arg;
        int         kind;
        int         port;
    } op_t;

    typedef struct {
        int          scen;
        int          addr;
        logic [15:0] exp;
    } chk_t;

    op_t  ops [6];
    chk_t chks [$];

    fbuf_port_sched dut (
        .clk(clk), .res(res),
        .op_start(op_start), .op_code(op_code), .op_arg(op_arg),
        .op_busy(op_busy), .op_done(op_done),
        .blit_req(blit_req), .blit_gnt(blit_gnt),
        .blit_en(blit_en), .blit_write(blit_write),
        .blit_addr(blit_addr), .blit_data(blit_data),
        .fbuf_en(fbuf_en), .fbuf_write(fbuf_write),
        .fbuf_addr(fbuf_addr), .fbuf_data_in(fbuf_data_in),
        .fbuf_data_out(fbuf_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // framebuffer with one-cycle read latency
    always @(posedge clk) begin
        if (fbuf_en) begin
            if (fbuf_write) mem[fbuf_addr] <= fbuf_data_in;
            else            rd_q <= mem[fbuf_addr];
        end
    end
    assign fbuf_data_out = rd_q;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int kind, input int a);
        logic [8:0] a9;
        a9 = a[8:0];
        case (kind)
            0: return 16'h8000 | {7'd0, a9};
            1: return (a < 8) ? 16'hFFFF : 16'h0000;
            default: begin
                if (a >= 32 && a < 40) return 16'h4444;
                if (a == 40) return 16'h1234;
                if (a == 41) return 16'hABCD;
                return 16'h0000;
            end
        endcase
    endfunction

    function automatic int count_nonzero();
        int c;
        c = 0;
        for (int a = 0; a < 512; a++)
            if (mem[a] != 16'h0000) c++;
        return c;
    endfunction

    task automatic fill(input int kind);
        blit_req = 1'b1;
        for (int t = 0; t < 20 && !blit_gnt; t++) @(negedge clk);
        check("fill_gnt", {31'd0, blit_gnt}, 32'd1);
        for (int a = 0; a < 512; a++) begin
            blit_en    = 1'b1;
            blit_write = 1'b1;
            blit_addr  = a[8:0];
            blit_data  = pat(kind, a);
            @(negedge clk);
        end
        blit_en    = 1'b0;
        blit_write = 1'b0;
        blit_req   = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_op(input logic [1:0] c, input logic [3:0] a,
                          output int port, output int lat);
        op_code  = c;
        op_arg   = a;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        check("busy_after_start", {31'd0, op_busy}, 32'd1);
        port = 0;
        lat  = -1;
        for (int k = 0; k < 4000; k++) begin
            if (op_done) begin
                lat = k;
                break;
            end
            if (fbuf_en) port++;
            @(negedge clk);
        end
    endtask

    initial begin
        int port, lat, gnt_hi, seen;

        ops[0] = '{2'd0, 4'd0,  0, 512};
        ops[1] = '{2'd1, 4'd3,  1, 1000};
        ops[2] = '{2'd2, 4'd0,  2, 1024};
        ops[3] = '{2'd3, 4'd0,  2, 1024};
        ops[4] = '{2'd1, 4'd0,  1, 0};
        ops[5] = '{2'd1, 4'd15, 0, 904};

        chks.push_back('{0, 0,   16'h0000});
        chks.push_back('{0, 300, 16'h0000});
        chks.push_back('{0, 511, 16'h0000});
        chks.push_back('{1, 0,   16'h0000});
        chks.push_back('{1, 16,  16'h0000});
        chks.push_back('{1, 24,  16'hFFFF});
        chks.push_back('{1, 31,  16'hFFFF});
        chks.push_back('{1, 32,  16'h0000});
        chks.push_back('{1, 504, 16'h0000});
        chks.push_back('{2, 40,  16'h0123});
        chks.push_back('{2, 41,  16'h4ABC});
        chks.push_back('{2, 42,  16'hD000});
        chks.push_back('{2, 43,  16'h0000});
        chks.push_back('{2, 32,  16'h0444});
        chks.push_back('{2, 33,  16'h4444});
        chks.push_back('{2, 39,  16'h4444});
        chks.push_back('{2, 48,  16'h0000});
        chks.push_back('{3, 40,  16'h234A});
        chks.push_back('{3, 41,  16'hBCD0});
        chks.push_back('{3, 42,  16'h0000});
        chks.push_back('{3, 39,  16'h4440});
        chks.push_back('{3, 32,  16'h4444});
        chks.push_back('{4, 0,   16'hFFFF});
        chks.push_back('{4, 7,   16'hFFFF});
        chks.push_back('{4, 8,   16'h0000});
        chks.push_back('{5, 120, 16'h8000});
        chks.push_back('{5, 511, 16'h8187});
        chks.push_back('{5, 119, 16'h0000});
        chks.push_back('{5, 0,   16'h0000});

        res        = 1'b1;
        op_start   = 1'b0;
        op_code    = 2'd0;
        op_arg     = 4'd0;
        blit_req   = 1'b0;
        blit_en    = 1'b0;
        blit_write = 1'b0;
        blit_addr  = 9'd0;
        blit_data  = 16'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, op_busy}, 32'd0);
        check("rst_done", {31'd0, op_done}, 32'd0);
        check("rst_gnt", {31'd0, blit_gnt}, 32'd0);
        check("rst_en", {31'd0, fbuf_en}, 32'd0);
        check("rst_write", {31'd0, fbuf_write}, 32'd0);
        check("rst_addr", {23'd0, fbuf_addr}, 32'd0);
        check("rst_data", {16'd0, fbuf_data_in}, 32'd0);
        res = 1'b0;
        @(negedge clk);

        // first tie after reset: blitter wins
        blit_req = 1'b1;
        op_code  = 2'd0;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        check("tie1_blit_gnt", {31'd0, blit_gnt}, 32'd1);
        check("tie1_busy", {31'd0, op_busy}, 32'd1);
        blit_en    = 1'b1;
        blit_write = 1'b1;
        blit_addr  = 9'd7;
        blit_data  = 16'hBEEF;
        #1;
        check("blit_pass_en", {31'd0, fbuf_en}, 32'd1);
        check("blit_pass_addr", {23'd0, fbuf_addr}, 32'd7);
        check("blit_pass_data", {16'd0, fbuf_data_in}, 32'hBEEF);
        @(negedge clk);
        blit_en    = 1'b0;
        blit_write = 1'b0;
        check("blit_wrote", {16'd0, mem[7]}, 32'hBEEF);
        repeat (3) @(negedge clk);
        check("eng_waits_en", {31'd0, fbuf_en}, 32'd0);
        check("eng_waits_busy", {31'd0, op_busy}, 32'd1);
        blit_req = 1'b0;
        @(negedge clk);
        check("blit_release", {31'd0, blit_gnt}, 32'd0);
        // second tie, blitter was granted last: engine wins
        blit_req = 1'b1;
        @(negedge clk);
        check("tie2_no_blit", {31'd0, blit_gnt}, 32'd0);
        gnt_hi = 0;
        seen   = 0;
        for (int k = 0; k < 700; k++) begin
            if (op_done) begin
                seen = 1;
                break;
            end
            if (blit_gnt) gnt_hi++;
            @(negedge clk);
        end
        check("tie2_done_seen", seen, 1);
        check("tie2_no_overlap", gnt_hi, 0);
        @(negedge clk);
        check("gap_after_eng", {31'd0, blit_gnt}, 32'd0);
        @(negedge clk);
        check("blit_after_eng", {31'd0, blit_gnt}, 32'd1);
        check("tie2_cleared", {16'd0, mem[7]}, 32'd0);
        blit_req = 1'b0;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            fill(ops[i].kind);
            run_op(ops[i].code, ops[i].arg, port, lat);
            check($sformatf("op%0d_port", i), port, ops[i].port);
            check($sformatf("op%0d_lat", i), lat, ops[i].port + 1);
            @(negedge clk);
            check($sformatf("op%0d_pulse", i), {31'd0, op_done}, 32'd0);
            check($sformatf("op%0d_idle", i), {31'd0, op_busy}, 32'd0);
            foreach (chks[j])
                if (chks[j].scen == i)
                    check($sformatf("op%0d_a%0d", i, chks[j].addr),
                          {16'd0, mem[chks[j].addr]}, {16'd0, chks[j].exp});
            if (i == 0) check("clear_all", count_nonzero(), 0);
        end

        // abort mid SCROLL_DOWN
        fill(1);
        op_code  = 2'd1;
        op_arg   = 4'd3;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        repeat (40) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        check("abort_busy", {31'd0, op_busy}, 32'd0);
        check("abort_en", {31'd0, fbuf_en}, 32'd0);
        check("abort_done", {31'd0, op_done}, 32'd0);
        seen = 0;
        for (int k = 0; k < 1100; k++) begin
            if (op_done) seen++;
            @(negedge clk);
        end
        check("abort_no_done", seen, 0);
        run_op(2'd0, 4'd0, port, lat);
        check("post_abort_port", port, 512);
        check("post_abort_lat", lat, 513);
        @(negedge clk);
        check("post_abort_all", count_nonzero(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
